// File: rtl/rx_buffer_ctrl.sv
// rx_buffer_ctrl: sequences the receive-message block RAM.
// Deframed words are written from address 0. When the frame ends, the
// buffer is locked and handed to the downstream reader until it
// acknowledges. The writer and the reader are active in disjoint states,
// so they share the single RAM address port without contention.
// Optional feature macro: RX_CHECKSUM_EN. When it is defined, the eof word
// must equal the XOR of the preceding frame words, and it is not counted
// in msg_len.
module rx_buffer_ctrl #(
  parameter int LOGSIZE = 10,
  parameter int WIDTH   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_valid,
  input  logic               rx_sof,
  input  logic               rx_eof,
  input  logic [WIDTH-1:0]   rx_data,
  output logic               rx_ready,
  output logic               ram_we,
  output logic [LOGSIZE-1:0] ram_addr,
  output logic [WIDTH-1:0]   ram_din,
  input  logic [WIDTH-1:0]   ram_dout,
  output logic               msg_ready,
  output logic [LOGSIZE:0]   msg_len,
  input  logic               rd_req,
  input  logic [LOGSIZE-1:0] rd_addr,
  output logic               rd_valid,
  output logic [WIDTH-1:0]   rd_data,
  input  logic               msg_ack,
  output logic               overflow,
  output logic               chk_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;
  localparam logic [1:0] ST_READY = 2'd3;

  localparam logic [LOGSIZE:0] PTR_ZERO = {(LOGSIZE+1){1'b0}};
  localparam logic [LOGSIZE:0] PTR_ONE  = {{LOGSIZE{1'b0}}, 1'b1};

  logic [1:0]         state_q,    state_d;
  logic [LOGSIZE:0]   wr_ptr_q,   wr_ptr_d;
  logic [LOGSIZE:0]   msg_len_q,  msg_len_d;
  logic               overflow_q, overflow_d;
  logic               chk_err_q,  chk_err_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_hit_q,   rd_hit_d;
  logic               accept_s;
  logic               ram_we_s;

`ifdef RX_CHECKSUM_EN
  logic [WIDTH-1:0]   xor_q, xor_d;

  // The eof word is valid when it equals the running XOR of the earlier words.
  function automatic logic chk_match(input logic [WIDTH-1:0] acc,
                                     input logic [WIDTH-1:0] word);
    return (acc == word);
  endfunction
`endif

  // The writer may take a word in every state except while a message is held.
  assign rx_ready = (state_q != ST_READY);
  assign accept_s = rx_valid & rx_ready;

  // A sof word always lands at address 0, whatever the write pointer holds.
  assign ram_addr = (state_q == ST_READY)   ? rd_addr :
                    (accept_s && rx_sof)    ? {LOGSIZE{1'b0}} :
                                              wr_ptr_q[LOGSIZE-1:0];
  assign ram_din  = rx_data;
  assign ram_we   = ram_we_s;

  assign msg_ready = (state_q == ST_READY);
  assign msg_len   = msg_len_q;
  assign overflow  = overflow_q;
  assign chk_err   = chk_err_q;
  assign rd_valid  = rd_valid_q;
  // RAM data arrives one cycle after the address, aligned with rd_valid.
  assign rd_data   = (rd_valid_q && rd_hit_q) ? ram_dout : {WIDTH{1'b0}};

  // Frame sequencing: write decisions, pointer, length and error flags.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    msg_len_d  = msg_len_q;
    overflow_d = overflow_q;
    chk_err_d  = 1'b0;
    ram_we_s   = 1'b0;
`ifdef RX_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    if (accept_s && rx_sof) begin
      // A sof starts a fresh frame from any writer state.
      ram_we_s   = 1'b1;
      wr_ptr_d   = PTR_ONE;
      overflow_d = 1'b0;
      if (rx_eof) begin
`ifdef RX_CHECKSUM_EN
        // A lone word has no payload to protect, so it is rejected.
        state_d   = ST_IDLE;
        wr_ptr_d  = PTR_ZERO;
        chk_err_d = 1'b1;
`else
        state_d   = ST_READY;
        msg_len_d = PTR_ONE;
`endif
      end else begin
        state_d = ST_RECV;
`ifdef RX_CHECKSUM_EN
        xor_d   = rx_data;
`endif
      end
    end else begin
      case (state_q)
        ST_RECV: begin
          if (accept_s) begin
            if (!wr_ptr_q[LOGSIZE]) begin
              ram_we_s = 1'b1;
              wr_ptr_d = wr_ptr_q + PTR_ONE;
              if (rx_eof) begin
`ifdef RX_CHECKSUM_EN
                if (chk_match(xor_q, rx_data)) begin
                  state_d   = ST_READY;
                  msg_len_d = wr_ptr_q;
                end else begin
                  state_d   = ST_IDLE;
                  wr_ptr_d  = PTR_ZERO;
                  chk_err_d = 1'b1;
                end
`else
                state_d   = ST_READY;
                msg_len_d = wr_ptr_q + PTR_ONE;
`endif
              end else begin
`ifdef RX_CHECKSUM_EN
                xor_d   = xor_q ^ rx_data;
`endif
                state_d = ST_RECV;
              end
            end else begin
              // Buffer full: discard the rest of this frame.
              overflow_d = 1'b1;
              if (rx_eof) begin
                state_d  = ST_IDLE;
                wr_ptr_d = PTR_ZERO;
              end else begin
                state_d  = ST_DROP;
              end
            end
          end else begin
            state_d = ST_RECV;
          end
        end
        ST_DROP: begin
          if (accept_s && rx_eof) begin
            state_d  = ST_IDLE;
            wr_ptr_d = PTR_ZERO;
          end else begin
            state_d  = ST_DROP;
          end
        end
        ST_READY: begin
          if (msg_ack) begin
            state_d  = ST_IDLE;
            wr_ptr_d = PTR_ZERO;
          end else begin
            state_d  = ST_READY;
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d  = ST_IDLE;
          wr_ptr_d = PTR_ZERO;
        end
      endcase
    end
  end

  // Reader side: a request is served only while the message is held.
  always_comb begin
    if (state_q == ST_READY) begin
      rd_valid_d = rd_req;
      rd_hit_d   = ({1'b0, rd_addr} < msg_len_q);
    end else begin
      rd_valid_d = 1'b0;
      rd_hit_d   = 1'b0;
    end
  end

  // State and bookkeeping registers; reset discards any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= PTR_ZERO;
      msg_len_q  <= PTR_ZERO;
      overflow_q <= 1'b0;
      chk_err_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
`ifdef RX_CHECKSUM_EN
      xor_q      <= {WIDTH{1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      msg_len_q  <= msg_len_d;
      overflow_q <= overflow_d;
      chk_err_q  <= chk_err_d;
      rd_valid_q <= rd_valid_d;
      rd_hit_q   <= rd_hit_d;
`ifdef RX_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

endmodule

// File: doc/rx_buffer_ctrl.md
Name: rx_buffer_ctrl

Overview:
- Sequences the receive-message block RAM.
- Accepts framed words from the laser receiver deframer and writes them sequentially from address 0.
- On end-of-frame, locks the buffer and hands the complete message to the downstream reader (display/UART), then waits for an acknowledge.
- Owns the RAM's single address port; writer and reader never contend because they are active in disjoint states.

Parameters:
- LOGSIZE, 10, log2 of RAM depth in words; capacity CAP = 2^LOGSIZE.
- WIDTH, 64, data word width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_valid  in  1  receiver word strobe.
- rx_sof  in  1  word is first of frame; qualified by rx_valid.
- rx_eof  in  1  word is last of frame; qualified by rx_valid.
- rx_data  in  WIDTH  receiver word.
- rx_ready  out  1  controller can accept a word.
- ram_we  out  1  RAM write enable.
- ram_addr  out  LOGSIZE  RAM address.
- ram_din  out  WIDTH  RAM write data.
- ram_dout  in  WIDTH  RAM read data; 1-cycle latency.
- msg_ready  out  1  complete message held in RAM.
- msg_len  out  LOGSIZE+1  word count of held message.
- rd_req  in  1  reader read request.
- rd_addr  in  LOGSIZE  reader word address.
- rd_valid  out  1  rd_data valid.
- rd_data  out  WIDTH  read word.
- msg_ack  in  1  reader done; releases buffer.
- overflow  out  1  sticky: a frame exceeded CAP.
- chk_err  out  1  checksum-mismatch pulse.

Behaviour:
- Reset (async, any state): state=IDLE, wr_ptr=0, msg_len=0, msg_ready=0, rd_valid=0, rd_data=0, overflow=0, chk_err=0. Any partial or held message is discarded.
- Accept rule: a word is accepted iff rx_valid & rx_ready.
  - rx_ready = 1 in IDLE, RECV and DROP; 0 in READY (combinational from state).
- Address mux: ram_addr = rd_addr in READY, else wr_ptr[LOGSIZE-1:0].
- Write path: ram_din = rx_data; ram_we = 1 only on an accepted word that is written, same cycle, no latency.
- IDLE:
  - Accepted word without sof is ignored (no write).
  - Accepted sof writes addr 0, sets wr_ptr=1 and clears overflow.
  - If sof&eof: go to READY with msg_len=1. Otherwise go to RECV.
- RECV:
  - Accepted word with sof: restarts the frame, writes addr 0, wr_ptr=1; the prior partial frame is abandoned.
  - Accepted word with wr_ptr<CAP: writes at wr_ptr, then wr_ptr+1.
  - If that word has eof: msg_len = wr_ptr+1, go to READY.
  - Accepted word with wr_ptr==CAP: no write, overflow=1. If the word has eof go to IDLE, else go to DROP.
  - A full CAP-word frame whose CAP-th word carries eof is legal: msg_len=CAP.
- DROP:
  - Consume words without writing.
  - eof goes to IDLE; sof behaves as in IDLE, leaving overflow=1 until the next sof is written.
- READY:
  - msg_ready=1; msg_len is stable.
  - rd_req at cycle N gives rd_valid=1 at N+1, with rd_data=ram_dout if rd_addr<msg_len, else 0.
  - Back-to-back requests are allowed, one per cycle.
  - msg_ack moves to IDLE; msg_ready=0 on the next cycle.
  - A read issued in the same cycle as msg_ack still completes at N+1.
- Outside READY: rd_req is ignored and rd_valid stays 0. msg_ack outside READY is ignored.
- msg_len stays at its last value after release and is updated only on the next completed frame.

Optional Feature:
- Macro RX_CHECKSUM_EN.
- When defined:
  - The eof word is the XOR of all preceding frame words. It is written to RAM but excluded from msg_len (msg_len = wr_ptr).
  - On mismatch, or on a single-word sof&eof frame: go to IDLE instead of READY, chk_err=1 for exactly one cycle, msg_ready stays 0.
  - A running XOR register resets on sof.
- When undefined: no XOR logic; chk_err is tied 0; msg_len counts the eof word.

Test Plan:
- Reset, then frame of 4 words 0x11,0x22,0x33,0x44 (sof on first, eof on last) → ram_we for 4 cycles at addrs 0..3; msg_ready=1, msg_len=4, rx_ready=0.
- In READY, rd_req at addrs 0..3 on consecutive cycles → rd_valid on the 4 following cycles with data 0x11..0x44. rd_addr=7 → rd_data=0. msg_ack → msg_ready=0, rx_ready=1.
- LOGSIZE=2, 6-word frame → addrs 0..3 written, overflow=1, state DROP until eof, msg_ready never asserts. Next 1-word sof&eof frame → overflow=0, msg_len=1.
- sof mid-frame after 2 words, then 3-word frame ending in eof → msg_len=3, addr 0 holds the new first word.
- Assert reset during RECV after 2 words, then send a 2-word frame → msg_len=2, no stale state.
- RX_CHECKSUM_EN: frame 0x5,0x3,0x6 → msg_len=2, msg_ready=1. Frame 0x5,0x3,0x7 → chk_err one-cycle pulse, msg_ready=0, rx_ready=1.
